// File: rtl/sdram_arbiter_pkg.sv
// Shared parameters and state encoding for the SDRAM command arbiter and its burst pointers.
package sdram_arbiter_pkg;

    localparam int ASIZE      = 13;
    localparam int BSIZE      = 2;
    localparam int CSIZE      = 9;
    localparam int LSIZE      = BSIZE + ASIZE + CSIZE;
    localparam int BURST_LEN  = 8;
    localparam int REF_PERIOD = 1562;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        IDLE      = 3'd1,
        REF       = 3'd2,
        WRITE     = 3'd3,
        READ      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_burst_ptr.sv
// Wrapping linear burst pointer: reload from the region start, or step by one burst
// and fall back to the start once the region end is reached.
module sdram_burst_ptr #(
    parameter int LSIZE     = 24,
    parameter int BURST_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [LSIZE-1:0] start_addr,
    input  logic [LSIZE-1:0] max_addr,
    output logic [LSIZE-1:0] ptr
);

    logic [LSIZE-1:0] nxt;

    // Carry out of the MSB is intentionally dropped; max_addr is exclusive.
    assign nxt = ptr + LSIZE'(BURST_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= start_addr;
        end else if (advance) begin
            ptr <= (nxt >= max_addr) ? start_addr : nxt;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Command scheduler in front of the SDRAM command engine: refresh timer, round-robin
// write/read arbitration and bank/row/column presentation of the granted burst.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ASIZE      = sdram_arbiter_pkg::ASIZE,
    parameter int BSIZE      = sdram_arbiter_pkg::BSIZE,
    parameter int CSIZE      = sdram_arbiter_pkg::CSIZE,
    parameter int LSIZE      = BSIZE + ASIZE + CSIZE,
    parameter int BURST_LEN  = sdram_arbiter_pkg::BURST_LEN,
    parameter int REF_PERIOD = sdram_arbiter_pkg::REF_PERIOD
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             init_done,
    input  logic             Wr_req,
    input  logic             Rd_req,
    input  logic [LSIZE-1:0] Wr_addr,
    input  logic [LSIZE-1:0] Wr_max_addr,
    input  logic             Wr_load,
    input  logic [LSIZE-1:0] Rd_addr,
    input  logic [LSIZE-1:0] Rd_max_addr,
    input  logic             Rd_load,
    output logic             ref_en,
    input  logic             ref_done,
    output logic             wr_en,
    input  logic             wr_done,
    output logic             rd_en,
    input  logic             rd_done,
    output logic [BSIZE-1:0] sd_baddr,
    output logic [ASIZE-1:0] sd_raddr,
    output logic [CSIZE-1:0] sd_caddr,
    output logic [2:0]       main_state,
    output logic             ref_overrun
);

    localparam int TW = $clog2(REF_PERIOD);

    arb_state_t       state, next_state;
    logic [TW-1:0]    ref_timer;
    logic             ref_pending;
    logic             rr_last_wr;
    logic             timer_run, ref_tc;
    logic             grant_ref, grant_wr, grant_rd;
    logic [LSIZE-1:0] wr_ptr, rd_ptr;

    assign main_state = state;

    // The timer already counts on the edge that leaves WAIT_INIT, so the first
    // refresh request lands exactly REF_PERIOD cycles after init completes.
    assign timer_run = (state != WAIT_INIT) || init_done;
    assign ref_tc    = timer_run && (ref_timer == TW'(REF_PERIOD - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ref_timer   <= '0;
            ref_pending <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (!timer_run || ref_tc) begin
                ref_timer <= '0;
            end else begin
                ref_timer <= ref_timer + TW'(1);
            end
            if (ref_tc) begin
                ref_pending <= 1'b1;
            end else if (grant_ref) begin
                ref_pending <= 1'b0;
            end
            if (ref_tc && ref_pending) begin
                ref_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= WAIT_INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_ref  = 1'b0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        case (state)
            WAIT_INIT: if (init_done) next_state = IDLE;
            IDLE: begin
                if (ref_pending) begin
                    next_state = REF;
                    grant_ref  = 1'b1;
                end else if (Wr_req && (!Rd_req || !rr_last_wr)) begin
                    next_state = WRITE;
                    grant_wr   = 1'b1;
                end else if (Rd_req) begin
                    next_state = READ;
                    grant_rd   = 1'b1;
                end
            end
            REF:     if (ref_done) next_state = IDLE;
            WRITE:   if (wr_done)  next_state = IDLE;
            READ:    if (rd_done)  next_state = IDLE;
            default: next_state = WAIT_INIT;
        endcase
    end

    // Address outputs are captured only at grant, so a pointer reload never disturbs a burst in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ref_en     <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            rr_last_wr <= 1'b0;
            sd_baddr   <= '0;
            sd_raddr   <= '0;
            sd_caddr   <= '0;
        end else begin
            ref_en <= grant_ref;
            wr_en  <= grant_wr;
            rd_en  <= grant_rd;
            if (grant_wr) begin
                rr_last_wr <= 1'b1;
                sd_caddr   <= wr_ptr[CSIZE-1:0];
                sd_raddr   <= wr_ptr[CSIZE+ASIZE-1:CSIZE];
                sd_baddr   <= wr_ptr[LSIZE-1:CSIZE+ASIZE];
            end else if (grant_rd) begin
                rr_last_wr <= 1'b0;
                sd_caddr   <= rd_ptr[CSIZE-1:0];
                sd_raddr   <= rd_ptr[CSIZE+ASIZE-1:CSIZE];
                sd_baddr   <= rd_ptr[LSIZE-1:CSIZE+ASIZE];
            end
        end
    end

    sdram_burst_ptr #(
        .LSIZE     (LSIZE),
        .BURST_LEN (BURST_LEN)
    ) u_wr_ptr (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .load       (Wr_load),
        .advance    ((state == WRITE) && wr_done),
        .start_addr (Wr_addr),
        .max_addr   (Wr_max_addr),
        .ptr        (wr_ptr)
    );

    sdram_burst_ptr #(
        .LSIZE     (LSIZE),
        .BURST_LEN (BURST_LEN)
    ) u_rd_ptr (
        .clk        (Clk),
        .rst_n      (Rst_n),
        .load       (Rd_load),
        .advance    ((state == READ) && rd_done),
        .start_addr (Rd_addr),
        .max_addr   (Rd_max_addr),
        .ptr        (rd_ptr)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: refresh timing, round-robin grants, pointer wrap,
// refresh precedence, refresh overrun and reset mid-burst.
module tb_sdram_arbiter;

    localparam int ASIZE = 13;
    localparam int BSIZE = 2;
    localparam int CSIZE = 9;
    localparam int LSIZE = 24;

    logic             Clk;
    logic             Rst_n;
    logic             init_done;
    logic             Wr_req, Rd_req;
    logic [LSIZE-1:0] Wr_addr, Wr_max_addr, Rd_addr, Rd_max_addr;
    logic             Wr_load, Rd_load;
    logic             ref_en, ref_done, wr_en, wr_done, rd_en, rd_done;
    logic [BSIZE-1:0] sd_baddr;
    logic [ASIZE-1:0] sd_raddr;
    logic [CSIZE-1:0] sd_caddr;
    logic [2:0]       main_state;
    logic             ref_overrun;

    int total_checks = 0;
    int bad_checks   = 0;
    int kind;
    bit early;

    int exp_kind[5]  = '{2, 3, 2, 3, 2};
    int exp_caddr[5] = '{0, 0, 8, 8, 16};

    sdram_arbiter #(
        .ASIZE      (ASIZE),
        .BSIZE      (BSIZE),
        .CSIZE      (CSIZE),
        .LSIZE      (LSIZE),
        .BURST_LEN  (8),
        .REF_PERIOD (100)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .init_done   (init_done),
        .Wr_req      (Wr_req),
        .Rd_req      (Rd_req),
        .Wr_addr     (Wr_addr),
        .Wr_max_addr (Wr_max_addr),
        .Wr_load     (Wr_load),
        .Rd_addr     (Rd_addr),
        .Rd_max_addr (Rd_max_addr),
        .Rd_load     (Rd_load),
        .ref_en      (ref_en),
        .ref_done    (ref_done),
        .wr_en       (wr_en),
        .wr_done     (wr_done),
        .rd_en       (rd_en),
        .rd_done     (rd_done),
        .sd_baddr    (sd_baddr),
        .sd_raddr    (sd_raddr),
        .sd_caddr    (sd_caddr),
        .main_state  (main_state),
        .ref_overrun (ref_overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // kind: 0 = nothing within limit, 1 = ref_en, 2 = wr_en, 3 = rd_en
    task automatic waitAnyEn(input int limit, output int k);
        k = 0;
        for (int i = 0; i < limit && k == 0; i++) begin
            @(negedge Clk);
            if (ref_en)     k = 1;
            else if (wr_en) k = 2;
            else if (rd_en) k = 3;
        end
    endtask

    // Next write/read grant, answering any refresh that gets in the way.
    task automatic nextBurst(output int k);
        int  got;
        int  tries;
        bit  found;
        k     = 0;
        tries = 0;
        found = 1'b0;
        while (!found && tries < 4) begin
            waitAnyEn(200, got);
            if (got == 1) begin
                ref_done = 1'b1;
                @(negedge Clk);
                ref_done = 1'b0;
            end else begin
                k     = got;
                found = 1'b1;
            end
            tries++;
        end
    endtask

    task automatic finishBurst(input int k);
        repeat (9) @(negedge Clk);
        if (k == 2) wr_done = 1'b1;
        if (k == 3) rd_done = 1'b1;
        @(negedge Clk);
        wr_done = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic applyStimulus();
        // reset and init timing
        Rst_n = 1'b0; init_done = 1'b0; Wr_req = 1'b0; Rd_req = 1'b0;
        Wr_addr = '0; Wr_max_addr = 24'd1000; Rd_addr = '0; Rd_max_addr = 24'd1000;
        Wr_load = 1'b0; Rd_load = 1'b0; ref_done = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("rst_ref_en", ref_en, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_rd_en", rd_en, 0);
        checkOutput("rst_caddr", sd_caddr, 0);
        checkOutput("rst_raddr", sd_raddr, 0);
        checkOutput("rst_baddr", sd_baddr, 0);
        checkOutput("rst_state", main_state, 0);
        checkOutput("rst_overrun", ref_overrun, 0);
        Rst_n = 1'b1;
        repeat (50) @(negedge Clk);
        checkOutput("wait_init_held", main_state, 0);
        checkOutput("no_ref_in_wait_init", ref_en, 0);
        init_done = 1'b1;
        early = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge Clk);
            if (k == 1) checkOutput("idle_after_init", main_state, 1);
            if (ref_en) early = 1'b1;
        end
        checkOutput("ref_not_early", early, 0);
        @(negedge Clk);
        checkOutput("first_ref_en", ref_en, 1);
        checkOutput("ref_state", main_state, 2);
        ref_done = 1'b1;
        @(negedge Clk);
        ref_done = 1'b0;
        checkOutput("ref_en_pulse", ref_en, 0);
        checkOutput("idle_after_ref", main_state, 1);

        // round-robin with both requests held
        Wr_req = 1'b1; Rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nextBurst(kind);
            checkOutput($sformatf("rr_kind%0d", i), kind, exp_kind[i]);
            checkOutput($sformatf("rr_caddr%0d", i), sd_caddr, exp_caddr[i]);
            if (i == 4) begin
                Wr_req = 1'b0; Rd_req = 1'b0;
            end
            finishBurst(kind);
        end

        // write pointer wrap at region end
        @(negedge Clk);
        Wr_addr = 24'd992; Wr_load = 1'b1;
        @(negedge Clk);
        Wr_load = 1'b0; Wr_addr = '0; Wr_req = 1'b1;
        nextBurst(kind);
        checkOutput("wrap_kind_a", kind, 2);
        checkOutput("load_caddr", sd_caddr, 480);
        checkOutput("load_raddr", sd_raddr, 1);
        checkOutput("load_baddr", sd_baddr, 0);
        finishBurst(kind);
        nextBurst(kind);
        Wr_req = 1'b0;
        checkOutput("wrap_kind_b", kind, 2);
        checkOutput("wrap_caddr", sd_caddr, 0);
        checkOutput("wrap_raddr", sd_raddr, 0);
        finishBurst(kind);

        // refresh pending during a write is served before the waiting read
        waitAnyEn(150, kind);
        checkOutput("t4_ref_sync", kind, 1);
        ref_done = 1'b1;
        @(negedge Clk);
        ref_done = 1'b0;
        repeat (79) @(negedge Clk);
        Wr_req = 1'b1;
        @(negedge Clk);
        checkOutput("t4_wr_en", wr_en, 1);
        Rd_req = 1'b1;
        repeat (29) @(negedge Clk);
        wr_done = 1'b1;
        @(negedge Clk);
        wr_done = 1'b0;
        checkOutput("t4_idle_gap", main_state, 1);
        checkOutput("t4_no_ref_on_done", ref_en, 0);
        @(negedge Clk);
        checkOutput("t4_ref_first", ref_en, 1);
        checkOutput("t4_rd_waits", rd_en, 0);
        ref_done = 1'b1;
        @(negedge Clk);
        ref_done = 1'b0;
        @(negedge Clk);
        checkOutput("t4_rd_en", rd_en, 1);
        checkOutput("t4_rd_caddr", sd_caddr, 16);
        Wr_req = 1'b0; Rd_req = 1'b0;
        finishBurst(3);

        // refresh overrun with ref_done withheld
        waitAnyEn(150, kind);
        checkOutput("t5_ref_sync", kind, 1);
        for (int c = 1; c <= 252; c++) begin
            @(negedge Clk);
            if (c == 20)  wr_done = 1'b1;
            if (c == 21)  wr_done = 1'b0;
            if (c == 22)  checkOutput("t5_foreign_done_ignored", main_state, 2);
            if (c == 198) checkOutput("t5_overrun_before", ref_overrun, 0);
            if (c == 199) checkOutput("t5_overrun_set", ref_overrun, 1);
            if (c == 250) ref_done = 1'b1;
            if (c == 251) ref_done = 1'b0;
            if (c == 252) begin
                checkOutput("t5_pending_ref", ref_en, 1);
                checkOutput("t5_overrun_sticky", ref_overrun, 1);
            end
        end
        ref_done = 1'b1;
        @(negedge Clk);
        ref_done = 1'b0;

        // reset in the middle of a read
        Rd_req = 1'b1;
        nextBurst(kind);
        checkOutput("t6_rd_kind", kind, 3);
        checkOutput("t6_rd_caddr", sd_caddr, 24);
        Rst_n = 1'b0; Rd_req = 1'b0; init_done = 1'b0;
        #1;
        checkOutput("t6_rst_rd_en", rd_en, 0);
        checkOutput("t6_rst_caddr", sd_caddr, 0);
        checkOutput("t6_rst_state", main_state, 0);
        checkOutput("t6_rst_overrun", ref_overrun, 0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        init_done = 1'b1; Rd_req = 1'b1;
        nextBurst(kind);
        Rd_req = 1'b0;
        checkOutput("t6_restart_kind", kind, 3);
        checkOutput("t6_restart_caddr", sd_caddr, 0);
        checkOutput("t6_restart_raddr", sd_raddr, 0);
        finishBurst(kind);
    endtask

    initial begin
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
